// File: rtl/fft3d_pkg.sv
// ---------------------------------------------------------------------------
// fft3d_pkg
// Shared constants and types for the 96-point 3-D FFT datapath.
//   CUBIC_D : cube edge length (even, <= 127)
//   HALF_D  : number of row pairs (CUBIC_D / 2)
//   IDX_W   : width of one buffer index
//   DATA_W  : width of one packed complex sample
//   state_t : transpose-buffer sequencer phases
//   order_t : nesting order of the shared index counters
// ---------------------------------------------------------------------------
package fft3d_pkg;

    localparam int CUBIC_D = 96;
    localparam int HALF_D  = CUBIC_D / 2;
    localparam int IDX_W   = 7;
    localparam int DATA_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // ORDER_WR: col fastest, then dep, then row.
    // ORDER_RD: row fastest, then col, then dep.
    typedef enum logic {
        ORDER_WR = 1'b0,
        ORDER_RD = 1'b1
    } order_t;

endpackage

// File: rtl/idx_cnt3.sv
// ---------------------------------------------------------------------------
// idx_cnt3
// Three wrapping index counters (row, col, dep) whose carry chain follows a
// selectable nesting order. row counts pairs (0..D/2-1); col and dep count
// 0..D-1.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   clr            : synchronous clear of all counters (wins over inc)
//   inc            : advance by one step in the selected order
//   order          : ORDER_WR or ORDER_RD nesting
//   row, col, dep  : current indices
//   last           : all three counters sit at their limit
// ---------------------------------------------------------------------------
module idx_cnt3
    import fft3d_pkg::*;
#(
    parameter int D = CUBIC_D,
    parameter int W = IDX_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    input  order_t       order,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic [W-1:0] dep,
    output logic         last
);

    localparam logic [W-1:0] FULL_MAX = W'(D - 1);
    localparam logic [W-1:0] HALF_MAX = W'(D / 2 - 1);

    logic row_wrap;
    logic col_wrap;
    logic dep_wrap;

    assign row_wrap = (row == HALF_MAX);
    assign col_wrap = (col == FULL_MAX);
    assign dep_wrap = (dep == FULL_MAX);
    assign last     = row_wrap & col_wrap & dep_wrap;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
            dep <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
            dep <= '0;
        end else if (inc) begin
            if (order == ORDER_WR) begin
                col <= col_wrap ? '0 : col + 1'b1;
                if (col_wrap) begin
                    dep <= dep_wrap ? '0 : dep + 1'b1;
                    if (dep_wrap) begin
                        row <= row_wrap ? '0 : row + 1'b1;
                    end
                end
            end else begin
                row <= row_wrap ? '0 : row + 1'b1;
                if (row_wrap) begin
                    col <= col_wrap ? '0 : col + 1'b1;
                    if (col_wrap) begin
                        dep <= dep_wrap ? '0 : dep + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/buf_seq.sv
// ---------------------------------------------------------------------------
// buf_seq
// Sequencer for the 3-D FFT transpose buffer. Accepts sample pairs over a
// valid/ready handshake and writes them in write order, then sweeps the
// buffer once in transposed order and re-times the 2-cycle read data into a
// valid-qualified stream.
// Ports:
//   clock, reset_n             : clock, asynchronous active-low reset
//   start                      : begin one frame (honoured only in IDLE)
//   in_valid / in_ready        : upstream pair handshake (ready only in WRITE)
//   in_data0 / in_data1        : even-row / odd-row sample of the pair
//   mem_wr / mem_rd            : registered buffer write / read strobes
//   row_no / col_no / dep_no   : registered buffer indices (row = pair index)
//   mem_wrdata0 / mem_wrdata1  : registered write data
//   mem_rddata0 / mem_rddata1  : buffer read data (2 cycles after mem_rd)
//   out_valid                  : downstream pair valid, no backpressure
//   out_data0 / out_data1      : pass-through of the buffer read data
//   busy                       : any phase other than IDLE
//   done                       : one-cycle pulse in the last DRAIN cycle
// ---------------------------------------------------------------------------
module buf_seq #(
    parameter int CUBIC_D = fft3d_pkg::CUBIC_D,
    parameter int IDX_W   = fft3d_pkg::IDX_W,
    parameter int DATA_W  = fft3d_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [IDX_W-1:0]  row_no,
    output logic [IDX_W-1:0]  col_no,
    output logic [IDX_W-1:0]  dep_no,
    output logic [DATA_W-1:0] mem_wrdata0,
    output logic [DATA_W-1:0] mem_wrdata1,
    input  logic [DATA_W-1:0] mem_rddata0,
    input  logic [DATA_W-1:0] mem_rddata1,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic              busy,
    output logic              done
);

    import fft3d_pkg::*;

    state_t             state;
    state_t             state_nx;

    logic               wr_hs;      // pair accepted this cycle
    logic               rd_issue;   // read issued this cycle
    logic               rd_end;     // whole read sweep has been issued
    logic               drain_cnt;  // second DRAIN cycle

    logic               cnt_clr;
    logic               cnt_inc;
    order_t             cnt_order;
    logic [IDX_W-1:0]   cnt_row;
    logic [IDX_W-1:0]   cnt_col;
    logic [IDX_W-1:0]   cnt_dep;
    logic               cnt_last;

    logic               rd_vld_d1;

    idx_cnt3 #(
        .D (CUBIC_D),
        .W (IDX_W)
    ) u_idx_cnt3 (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .order   (cnt_order),
        .row     (cnt_row),
        .col     (cnt_col),
        .dep     (cnt_dep),
        .last    (cnt_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)              state_nx = WRITE;
            WRITE:   if (wr_hs && cnt_last)  state_nx = READ;
            READ:    if (rd_end)             state_nx = DRAIN;
            DRAIN:   if (drain_cnt)          state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state == WRITE);
        busy     = (state != IDLE);
        done     = (state == DRAIN) && drain_cnt;
    end

    assign wr_hs    = in_valid && in_ready;
    assign rd_issue = (state == READ) && !rd_end;

    // Counters are cleared on entry to WRITE and on entry to READ, so the read
    // sweep starts at zero in the cycle right after the last write handshake.
    always_comb begin
        cnt_clr   = ((state == IDLE) && start) || (wr_hs && cnt_last);
        cnt_inc   = wr_hs || rd_issue;
        cnt_order = (state == WRITE) ? ORDER_WR : ORDER_RD;
    end

    // ---------------- output and phase-tracking registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            row_no      <= '0;
            col_no      <= '0;
            dep_no      <= '0;
            mem_wrdata0 <= '0;
            mem_wrdata1 <= '0;
            rd_vld_d1   <= 1'b0;
            out_valid   <= 1'b0;
            rd_end      <= 1'b0;
            drain_cnt   <= 1'b0;
        end else begin
            mem_wr <= wr_hs;
            mem_rd <= rd_issue;

            // Indices hold across input gaps in WRITE and rest at zero once
            // the strobes are idle in the other phases.
            if (wr_hs || rd_issue) begin
                row_no <= cnt_row;
                col_no <= cnt_col;
                dep_no <= cnt_dep;
            end else if (state != WRITE) begin
                row_no <= '0;
                col_no <= '0;
                dep_no <= '0;
            end

            if (wr_hs) begin
                mem_wrdata0 <= in_data0;
                mem_wrdata1 <= in_data1;
            end

            // Buffer read latency is two cycles; out_valid tracks it exactly.
            rd_vld_d1 <= mem_rd;
            out_valid <= rd_vld_d1;

            rd_end    <= (state == READ) && (rd_end || (rd_issue && cnt_last));
            drain_cnt <= (state == DRAIN) && !drain_cnt;
        end
    end

    assign out_data0 = mem_rddata0;
    assign out_data1 = mem_rddata1;

endmodule

// File: tb/tb_buf_seq.sv
// ---------------------------------------------------------------------------
// tb_buf_seq
// Directed bench for buf_seq with a reduced cube (D = 8, 256 pairs per frame)
// and a behavioural 2-cycle transpose buffer. Frames: reset mid-WRITE,
// continuous input, throttled input with stray starts, restart from IDLE.
// ---------------------------------------------------------------------------
module tb_buf_seq;

    localparam int D      = 8;
    localparam int H      = D / 2;
    localparam int IW     = 7;
    localparam int DW     = 64;
    localparam int NPAIRS = D * D * H;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic          mem_wr;
    logic          mem_rd;
    logic [IW-1:0] row_no;
    logic [IW-1:0] col_no;
    logic [IW-1:0] dep_no;
    logic [DW-1:0] mem_wrdata0;
    logic [DW-1:0] mem_wrdata1;
    logic [DW-1:0] mem_rddata0;
    logic [DW-1:0] mem_rddata1;
    logic          out_valid;
    logic [DW-1:0] out_data0;
    logic [DW-1:0] out_data1;
    logic          busy;
    logic          done;

    buf_seq #(
        .CUBIC_D (D),
        .IDX_W   (IW),
        .DATA_W  (DW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data0    (in_data0),
        .in_data1    (in_data1),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .row_no      (row_no),
        .col_no      (col_no),
        .dep_no      (dep_no),
        .mem_wrdata0 (mem_wrdata0),
        .mem_wrdata1 (mem_wrdata1),
        .mem_rddata0 (mem_rddata0),
        .mem_rddata1 (mem_rddata1),
        .out_valid   (out_valid),
        .out_data0   (out_data0),
        .out_data1   (out_data1),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural transpose buffer ----------------
    logic [DW-1:0] buf0 [NPAIRS];
    logic [DW-1:0] buf1 [NPAIRS];
    logic [DW-1:0] rd_s1_0, rd_s1_1;

    function automatic int addr_of(input int r, input int dp, input int c);
        return r * D * D + dp * D + c;
    endfunction

    always @(posedge clock) begin
        if (mem_wr) begin
            buf0[addr_of(int'(row_no), int'(dep_no), int'(col_no))] <= mem_wrdata0;
            buf1[addr_of(int'(row_no), int'(dep_no), int'(col_no))] <= mem_wrdata1;
        end
        if (mem_rd) begin
            rd_s1_0 <= buf0[addr_of(int'(row_no), int'(dep_no), int'(col_no))];
            rd_s1_1 <= buf1[addr_of(int'(row_no), int'(dep_no), int'(col_no))];
        end
        mem_rddata0 <= rd_s1_0;
        mem_rddata1 <= rd_s1_1;
    end

    // ---------------- cycle counter and monitor ----------------
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    bit            mon_en = 1'b0;
    int            wr_k, rd_k, out_k, done_cnt;
    int            last_wr_cyc, first_rd_cyc, prev_rd_cyc;
    logic [20:0]   cap_w97, cap_wlast, cap_r49;

    always @(negedge clock) begin
        if (mon_en) begin
            if (!busy) begin
                wr_k  = 0;
                rd_k  = 0;
                out_k = 0;
            end
            if (mem_wr) begin
                check("wr_idx", {row_no, dep_no, col_no},
                      {IW'(wr_k / (D * D)), IW'((wr_k / D) % D), IW'(wr_k % D)});
                check("wr_data0", mem_wrdata0, 64'(wr_k));
                check("wr_data1", mem_wrdata1, 64'(wr_k + 1));
                check("wr_rd_overlap", mem_rd, 1'b0);
                if (wr_k == 97)         cap_w97   = {row_no, dep_no, col_no};
                if (wr_k == NPAIRS - 1) cap_wlast = {row_no, dep_no, col_no};
                last_wr_cyc = cyc;
                wr_k++;
            end
            if (mem_rd) begin
                if (rd_k == 0) begin
                    check("rd_after_last_wr", cyc, last_wr_cyc + 1);
                    first_rd_cyc = cyc;
                end else begin
                    check("rd_continuous", cyc, prev_rd_cyc + 1);
                end
                check("rd_idx", {row_no, dep_no, col_no},
                      {IW'(rd_k % H), IW'(rd_k / (H * D)), IW'((rd_k / H) % D)});
                if (rd_k == 49) cap_r49 = {row_no, dep_no, col_no};
                prev_rd_cyc = cyc;
                rd_k++;
            end
            if (out_valid) begin
                if (out_k == 0) check("out_latency", cyc, first_rd_cyc + 2);
                check("out_data0", out_data0,
                      64'(addr_of(out_k % H, out_k / (H * D), (out_k / H) % D)));
                check("out_data1", out_data1,
                      64'(addr_of(out_k % H, out_k / (H * D), (out_k / H) % D) + 1));
                out_k++;
            end
            if (done) begin
                check("done_timing", cyc, prev_rd_cyc + 2);
                check("done_wr_count", wr_k, NPAIRS);
                check("done_rd_count", rd_k, NPAIRS);
                check("done_out_count", out_k, NPAIRS);
                done_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Pulses start, then offers pairs until n_pairs handshakes have occurred.
    // Throttled mode uses the valid pattern 1-0-0-1.
    task automatic drive_pairs(input int n_pairs, input bit throttle);
        int k     = 0;
        int t     = 0;
        int guard = 0;
        bit v;
        bit hs;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (k < n_pairs && guard < 4 * NPAIRS) begin
            v        = throttle ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            in_valid = v;
            in_data0 = 64'(k);
            in_data1 = 64'(k + 1);
            hs       = v && in_ready;
            @(posedge clock); #1;
            if (hs) k++;
            t++;
            guard++;
        end
        in_valid = 1'b0;
        check("pairs_accepted", k, n_pairs);
    endtask

    task automatic wait_done(input bit poke_start);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * NPAIRS && !seen; i++) begin
            @(posedge clock); #1;
            if (done) begin
                seen = 1'b1;
                if (poke_start) start = 1'b1;
            end
        end
        check("done_seen", seen, 1'b1);
        @(posedge clock); #1;
        start = 1'b0;
        check("idle_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data0 = '0;
        in_data1 = '0;
        wr_k = 0; rd_k = 0; out_k = 0; done_cnt = 0;
        last_wr_cyc = 0; first_rd_cyc = 0; prev_rd_cyc = 0;
        cap_w97 = '0; cap_wlast = '0; cap_r49 = '0;

        // Reset values.
        #12;
        check("rst_mem_wr",    mem_wr,    1'b0);
        check("rst_mem_rd",    mem_rd,    1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_idx",       {row_no, col_no, dep_no}, 21'd0);
        check("rst_wrdata",    mem_wrdata0 | mem_wrdata1, 64'd0);
        @(posedge clock); #3;
        reset_n = 1'b1;

        // Asynchronous reset in the middle of WRITE.
        drive_pairs(100, 1'b0);
        check("pre_rst_mem_wr", mem_wr, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_mem_wr",   mem_wr,   1'b0);
        check("midrst_mem_rd",   mem_rd,   1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_busy",     busy,     1'b0);
        check("midrst_idx",      {row_no, col_no, dep_no}, 21'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_rst_busy",     busy,     1'b0);
        check("post_rst_in_ready", in_ready, 1'b0);
        mon_en = 1'b1;

        // Frame A: continuous input.
        drive_pairs(NPAIRS, 1'b0);
        check("in_ready_after_last", in_ready, 1'b0);
        wait_done(1'b0);
        check("w97_idx",   cap_w97,   {7'd1, 7'd4, 7'd1});   // row 1, dep 4, col 1
        check("wlast_idx", cap_wlast, {7'd3, 7'd7, 7'd7});   // row 3, dep 7, col 7
        check("r49_idx",   cap_r49,   {7'd1, 7'd1, 7'd4});   // row 1, dep 1, col 4

        // Frame B: throttled input, stray start in READ and on the done cycle.
        drive_pairs(NPAIRS, 1'b1);
        check("in_ready_after_last_b", in_ready, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after_stray_start", busy, 1'b1);
        wait_done(1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            check("idle_hold", busy, 1'b0);
        end

        // Frame C: start from IDLE three cycles after done; indices begin at 0.
        drive_pairs(NPAIRS, 1'b0);
        wait_done(1'b0);
        check("done_count", done_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, done_count %0d", done_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/buf_seq.md
# buf_seq

Sequencer that drives the 3-D FFT transpose buffer (`buf_ctl`) of the 96-point 3-D FFT datapath. It accepts sample pairs from the upstream FFT stage through a valid/ready handshake and issues buffer writes in write order. It then issues one contiguous read sweep in transposed order and re-times the buffer's 2-cycle read data into a valid-qualified stream for the next FFT stage. It owns all `row_no`/`col_no`/`dep_no` generation, and the FFT stages never see buffer addressing.

## Interface
- `CUBIC_D`, 96: cube edge length; must be even and ≤ 127.
- `IDX_W`, 7: index width.
- `DATA_W`, 64: sample width (complex, packed).
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; begins one frame when in IDLE, ignored otherwise.
- `in_valid` in 1: upstream pair valid.
- `in_ready` out 1: high only in WRITE.
- `in_data0`, `in_data1` in DATA_W: even-row and odd-row samples of the pair.
- `mem_wr`, `mem_rd` out 1: buffer write and read strobes (registered).
- `row_no`, `col_no`, `dep_no` out IDX_W: buffer indices (registered); `row_no` is the pair index, 0..CUBIC_D/2-1.
- `mem_wrdata0`, `mem_wrdata1` out DATA_W: registered copies of `in_data0`/`in_data1`.
- `mem_rddata0`, `mem_rddata1` in DATA_W: buffer read data.
- `out_valid` out 1: downstream pair valid; no backpressure.
- `out_data0`, `out_data1` out DATA_W: combinational pass-through of `mem_rddata0`/`mem_rddata1`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- **FSM states:** IDLE, WRITE, READ, DRAIN, in that order.
  - IDLE → WRITE on `start`.
  - WRITE → READ when the last pair handshake occurs.
  - READ → DRAIN after the last read issues.
  - DRAIN → IDLE after 2 cycles. `done` pulses on the DRAIN→IDLE transition cycle.
- **WRITE:**
  - Handshake is `in_valid & in_ready`. Each handshake registers `mem_wr`=1, the current indices, and the data.
  - Order: `col_no` fastest (0..D-1), then `dep_no` (0..D-1), then `row_no` (0..D/2-1).
  - Gaps in `in_valid` are allowed. Counters advance only on a handshake.
  - The last handshake is at row=D/2-1, dep=D-1, col=D-1. Total pairs per frame is D·D·D/2 (442368 at D=96).
- **READ:**
  - `mem_rd`=1 every cycle, with no gaps. The buffer pipeline freezes when the strobe drops, so gaps are forbidden.
  - Order: `row_no` fastest (0..D/2-1), then `col_no`, then `dep_no`. The same pair count as WRITE.
- **Index counters:** one shared set of counters, reused between phases. All counters are cleared on entry to WRITE and on entry to READ. Each counter wraps to 0 at its limit and carries to the next counter.
- **Strobe idle values:** `mem_wr`/`mem_rd` are low, and indices hold 0, in IDLE and DRAIN.
- **`out_valid`:** equals `mem_rd` delayed by 2 flops. It therefore covers DRAIN and ends exactly with the last datum.
- **Buffer contents:** reset_n low does not clear the buffer contents. The buffer has its own reset.

## Timing
- **Reset values:** `mem_wr`, `mem_rd`, `out_valid`, `busy`, `done`, `in_ready` = 0. Indices and `mem_wrdata*` = 0. State = IDLE.
- **Write latency:** a handshake at edge n produces `mem_wr` and address/data at outputs after edge n; the buffer writes at edge n+1.
- **Read latency:** a read issued (`mem_rd` high) after edge n produces `out_valid` and data after edge n+2.
- **Phase transition:** the first `mem_rd` is asserted in the cycle directly after the last `mem_wr`. No bubble, no overlap.
- **`start` handling:** `start` during a busy frame is ignored. `start` coinciding with the `done` cycle is ignored; it must be re-asserted in IDLE.
- **Reset mid-frame:** asynchronous return to IDLE. All strobes drop immediately, and any partial frame is discarded.

## Structure
- Shared package `fft3d_pkg` holds:
  - `CUBIC_D`, `HALF_D`=CUBIC_D/2, `IDX_W`, `DATA_W`;
  - the state enum {IDLE, WRITE, READ, DRAIN}.
- Sub-module `idx_cnt3`: three wrapping counters with a selectable nesting order (write order / read order), plus `clr`, `inc` and `last` outputs. `buf_seq` holds the FSM, output registers and the 2-flop valid delay.

## Test plan
- **Reset:** assert reset_n low mid-WRITE (after pair 1000) → all strobes 0 in the same cycle. After release, state = IDLE and `busy`=0.
- **Write order:** `start`, then `in_valid` held high → pair k=97 appears with `mem_wr`=1, row=0, dep=1, col=1. The last pair has row=47, dep=95, col=95. `in_ready` drops the cycle after that handshake.
- **Throttled input:** `in_valid` toggled 1-0-0-1 → exactly one `mem_wr` per handshake, and indices never skip or repeat.
- **Read order and latency:** after WRITE, `mem_rd` is continuous for 442368 cycles. Read 49 shows row=1, col=1, dep=0. `out_valid` rises exactly 2 cycles after the first `mem_rd`.
- **End-to-end with `buf_ctl`:** write value row·9216+dep·96+col (even) / +1 (odd) → output pair n carries transposed indices matching the model. `done` pulses once, 2 cycles after the last `mem_rd`.
- **Stray `start`:** `start` during READ and on the `done` cycle → no effect. A `start` in IDLE 3 cycles later begins a new frame with indices 0.
